// File: rtl/parking_job_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | parking_job_arbiter: park/retrieve request FIFO with leak-evacuation   |
// | preemption and a job watchdog.                 Revision: 1.0           |
// +------------------------------------------------------------------------+
module parking_job_arbiter #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_req,
  input  logic        out_req,
  input  logic [15:0] req_plate,
  input  logic        leakage,
  input  logic [2:0]  leakage_floor,
  input  logic        evac_empty,
  output logic        job_valid,
  output logic [1:0]  job_type,
  output logic [15:0] job_plate,
  output logic [2:0]  job_floor,
  input  logic        job_ready,
  input  logic        job_done,
  output logic        busy,
  output logic [3:0]  queue_count,
  output logic        queue_full,
  output logic        drop_pulse,
  output logic        timeout_err,
  output logic        leak_active
);

  localparam int              c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
  localparam logic [3:0]      c_DEPTH4   = 4'(DEPTH);
  localparam logic [CW-1:0]   c_WD_ONE   = CW'(1);
  localparam logic [CW-1:0]   c_WD_LAST  = CW'(TIMEOUT - 1);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_OFFER_Q  = 2'd1;
  localparam logic [1:0] c_OFFER_EV = 2'd2;
  localparam logic [1:0] c_WAIT     = 2'd3;

  localparam logic [1:0] c_T_PARK = 2'b00;
  localparam logic [1:0] c_T_RET  = 2'b01;
  localparam logic [1:0] c_T_EVAC = 2'b10;

  logic [17:0]     r_mem [0:DEPTH-1];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [1:0]      r_state;
  logic [2:0]      r_leak_floor;
  logic [CW-1:0]   r_wdog;

  logic        w_req;
  logic [17:0] w_entry;
  logic        w_pop;
  logic        w_full;
  logic        w_push;
  logic        w_drop;
  logic [3:0]  w_count_nxt;
  logic        w_leak_now;
  logic        w_evac_go;
  logic [2:0]  w_floor_src;
  logic [17:0] w_head;

  always_comb begin
    w_req       = in_req | out_req;
    w_entry     = {(in_req ? c_T_PARK : c_T_RET), req_plate};
    w_pop       = (r_state == c_OFFER_Q) && job_valid && job_ready;
    w_full      = (queue_count == c_DEPTH4);
    w_push      = w_req && (!w_full || w_pop);
    // Simultaneous park+retrieve keeps the park; the retrieve is reported lost.
    w_drop      = (in_req && out_req) || (w_req && !w_push);
    w_count_nxt = queue_count + {3'b000, w_push} - {3'b000, w_pop};
    w_leak_now  = leakage && (leakage_floor != 3'd0);
    w_evac_go   = leak_active && !evac_empty;
    w_floor_src = w_leak_now ? leakage_floor : r_leak_floor;
    w_head      = r_mem[r_rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      queue_count <= 4'd0;
      queue_full  <= 1'b0;
      drop_pulse  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      queue_count <= w_count_nxt;
      queue_full  <= (w_count_nxt == c_DEPTH4);
      drop_pulse  <= w_drop;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= c_IDLE;
      r_leak_floor <= 3'd0;
      r_wdog       <= '0;
      leak_active  <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
      job_valid    <= 1'b0;
      job_type     <= 2'b00;
      job_plate    <= 16'd0;
      job_floor    <= 3'd0;
    end else begin
      leak_active <= w_leak_now;
      timeout_err <= 1'b0;
      // Floor is frozen outside IDLE/OFFER_Q so an accepted evacuation keeps its target.
      if (((r_state == c_IDLE) || (r_state == c_OFFER_Q)) && w_leak_now) begin
        r_leak_floor <= leakage_floor;
      end
      case (r_state)
        c_IDLE: begin
          if (w_evac_go) begin
            r_state   <= c_OFFER_EV;
            busy      <= 1'b1;
            job_valid <= 1'b1;
            job_type  <= c_T_EVAC;
            job_plate <= 16'd0;
            job_floor <= w_floor_src;
          end else if (queue_count != 4'd0) begin
            r_state   <= c_OFFER_Q;
            busy      <= 1'b1;
            job_valid <= 1'b1;
            job_type  <= w_head[17:16];
            job_plate <= w_head[15:0];
            job_floor <= 3'd0;
          end
        end
        c_OFFER_Q: begin
          if (w_pop) begin
            r_state   <= c_WAIT;
            r_wdog    <= '0;
            job_valid <= 1'b0;
            job_type  <= 2'b00;
            job_plate <= 16'd0;
          end else if (w_evac_go) begin
            r_state   <= c_OFFER_EV;
            job_valid <= 1'b0;
            job_type  <= 2'b00;
            job_plate <= 16'd0;
          end
        end
        c_OFFER_EV: begin
          if (job_valid && job_ready) begin
            r_state   <= c_WAIT;
            r_wdog    <= '0;
            job_valid <= 1'b0;
            job_type  <= 2'b00;
            job_floor <= 3'd0;
          end else if (!w_evac_go) begin
            r_state   <= c_IDLE;
            busy      <= 1'b0;
            job_valid <= 1'b0;
            job_type  <= 2'b00;
            job_floor <= 3'd0;
          end else if (!job_valid) begin
            job_valid <= 1'b1;
            job_type  <= c_T_EVAC;
            job_plate <= 16'd0;
            job_floor <= r_leak_floor;
          end
        end
        c_WAIT: begin
          if (job_done) begin
            r_state <= c_IDLE;
            busy    <= 1'b0;
          end else if (r_wdog == c_WD_LAST) begin
            r_state     <= c_IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            r_wdog <= r_wdog + c_WD_ONE;
          end
        end
        default: begin
          r_state <= c_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/parking_job_arbiter.md
Name: parking_job_arbiter

Overview:
- Sequences the parking-lot elevator datapath. Buffers park (in) and retrieve (out) requests in a small FIFO and issues them one job at a time over a valid/ready/done handshake.
- Leakage evacuation jobs preempt queued work at job boundaries. A watchdog guards against stalled jobs.
- Sits between the top-level input pins (license_plate, in_mode, out_mode, leakage, leakage_floor) and the elevator/slot datapath.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..8).
- TIMEOUT, 64, maximum cycles from job accept to job_done before abort.
- CW, 7, watchdog counter width (must hold TIMEOUT).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_req  in  1  one-cycle park request pulse.
- out_req  in  1  one-cycle retrieve request pulse.
- req_plate  in  16  BCD plate, sampled with in_req/out_req.
- leakage  in  1  level, high while leak present.
- leakage_floor  in  3  leaking floor, valid 1..7.
- evac_empty  in  1  datapath: latched leak floor holds no cars.
- job_valid  out  1  job offered to datapath.
- job_type  out  2  00 park, 01 retrieve, 10 evacuate.
- job_plate  out  16  plate for park/retrieve; 0 for evacuate.
- job_floor  out  3  leak floor for evacuate; 0 otherwise.
- job_ready  in  1  datapath accepts the offered job.
- job_done  in  1  one-cycle pulse, accepted job finished.
- busy  out  1  a job is offered or in progress.
- queue_count  out  4  FIFO occupancy, 0..DEPTH.
- queue_full  out  1  queue_count==DEPTH.
- drop_pulse  out  1  one-cycle pulse, request discarded.
- timeout_err  out  1  one-cycle pulse, watchdog abort.
- leak_active  out  1  registered leakage with valid floor.

Behaviour:
- Reset (reset==0, async): all outputs 0, FIFO empty, state IDLE, leak latch 0, watchdog 0.
- All outputs are registered.
- FIFO entry is {type, plate}.
  - Push at the rising edge where in_req or out_req is high.
  - in_req and out_req high together: push park only, pulse drop_pulse.
  - Full with no pop this cycle: discard the request, pulse drop_pulse the next cycle.
  - Full with a pop this cycle: push is accepted, count unchanged.
  - Pointers wrap modulo DEPTH.
- Leak latch:
  - leak_active <= leakage && leakage_floor != 0.
  - Latched floor updates only while state is IDLE or OFFER_Q, so it is stable during an evacuate job.
  - leakage_floor==0 is ignored.
- States IDLE, OFFER_Q, OFFER_EV, WAIT.
- IDLE:
  - Go to OFFER_EV if leak_active && !evac_empty.
  - Otherwise go to OFFER_Q if queue_count>0.
  - job_valid rises the cycle after the decision. A request pushed at edge N into an empty, idle arbiter gives job_valid=1 after edge N+1.
- OFFER_Q:
  - Drives the FIFO head with job_valid=1.
  - Fields are held stable until job_ready.
  - A leak arriving before acceptance withdraws the offer (job_valid<=0, head kept), then goes to OFFER_EV.
  - On job_ready: pop the head, clear the watchdog, go to WAIT.
- OFFER_EV:
  - Drives type 10 with the latched floor.
  - On job_ready: go to WAIT.
  - If leak_active falls or evac_empty rises before acceptance: withdraw and go to IDLE.
- WAIT:
  - job_valid=0, busy=1, watchdog increments.
  - job_done: go to IDLE. Back-to-back evacuate jobs repeat while leak_active && !evac_empty.
  - Watchdog reaches TIMEOUT-1 without job_done: pulse timeout_err, go to IDLE. The job is not re-queued.
- job_done outside WAIT is ignored. job_ready while job_valid==0 is ignored.
- Leak ending mid-job: the current job completes; no new evacuate jobs are issued; the queue resumes.
- busy = state != IDLE.

Test Plan:
- Basic park: reset low 2 cycles, release. in_req with plate 9423; job_ready=1, job_done 3 cycles after accept -> job_valid one cycle after push, job_type 00, job_plate 0x9423, queue_count 1->0, busy falls after done.
- Ordering/full, DEPTH=4: job_ready=0, push 9423, 8754, 9706, 2666, 7723 -> queue_full=1, drop_pulse once on 7723. Release job_ready -> jobs issued in FIFO order, 7723 never issued.
- Leak preempt: queue 8754 retrieve, raise leakage with floor 1 while job_ready=0 -> offer withdrawn, type 10 floor 1 offered. After 2 evac done pulses set evac_empty=1 -> retrieve 8754 then issued.
- Leak cut-off: leakage floor 1 high, evac job accepted, drop leakage mid-job -> job finishes on job_done, no second evacuate, queued job follows.
- Watchdog, TIMEOUT=64: accept job, never pulse job_done -> timeout_err one pulse 64 cycles after accept, state IDLE, next queued job offered.
- Simultaneous/async: in_req+out_req same cycle -> park pushed, drop_pulse=1. Assert reset low mid-WAIT between edges -> outputs 0 immediately, queue_count 0.
